// File: rtl/noc_pkg.sv
// Shared NoC definitions: route direction codes, default widths, and the
// modulo-5 port increment used by the round-robin pointers.
package noc_pkg;

  localparam int NOC_NUM_PORTS    = 5;
  localparam int NOC_PACKET_WIDTH = 32;
  localparam int NOC_DIR_W        = 3;

  typedef enum logic [NOC_DIR_W-1:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } dir_e;

  function automatic logic [NOC_DIR_W-1:0] wrap_inc(input logic [NOC_DIR_W-1:0] idx);
    return (idx >= 3'(LOCAL)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr_i, scanning upward modulo 5. Purely combinational, no state.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NOC_NUM_PORTS-1:0] req_i,
  input  logic [NOC_DIR_W-1:0]     ptr_i,
  output logic [NOC_NUM_PORTS-1:0] grant_o
);

  logic [NOC_DIR_W-1:0] idx;
  logic                 found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = ptr_i;
    for (int k = 0; k < NOC_NUM_PORTS; k++) begin
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// 5x5 switch allocator: per-output one-entry register with round-robin input
// selection; grant -> output in one cycle, same-cycle drain and refill.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int PACKET_WIDTH = NOC_PACKET_WIDTH,
  parameter int NUM_PORTS    = NOC_NUM_PORTS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              in_valid,
  input  logic [3*NUM_PORTS-1:0]            in_dir,
  input  logic [PACKET_WIDTH*NUM_PORTS-1:0] in_packet,
  output logic [NUM_PORTS-1:0]              in_ready,
  output logic [NUM_PORTS-1:0]              out_valid,
  output logic [PACKET_WIDTH*NUM_PORTS-1:0] out_packet,
  input  logic [NUM_PORTS-1:0]              out_ready,
  output logic                              drop_err
);

  logic [NUM_PORTS-1:0]    valid_q, valid_d;
  logic [PACKET_WIDTH-1:0] pkt_q [NUM_PORTS];
  logic [PACKET_WIDTH-1:0] pkt_d [NUM_PORTS];
  logic [NOC_DIR_W-1:0]    ptr_q [NUM_PORTS];
  logic [NOC_DIR_W-1:0]    ptr_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]    req   [NUM_PORTS];
  logic [NUM_PORTS-1:0]    grant [NUM_PORTS];
  logic [NUM_PORTS-1:0]    drop;

  // Only a free output sees requests, so a non-zero grant always means a load.
  always_comb begin
    drop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && !rst) begin
        if (in_dir[3*i +: 3] > 3'(LOCAL)) begin
          drop[i] = 1'b1;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (in_dir[3*i +: 3] == 3'(o) && (!valid_q[o] || out_ready[o])) begin
            req[o][i] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req_i   (req[o]),
      .ptr_i   (ptr_q[o]),
      .grant_o (grant[o])
    );
  end

  always_comb begin
    in_ready = drop;
    valid_d  = valid_q;
    pkt_d    = pkt_q;
    ptr_d    = ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (|grant[o]) begin
        valid_d[o] = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant[o][i]) begin
            pkt_d[o]    = in_packet[PACKET_WIDTH*i +: PACKET_WIDTH];
            ptr_d[o]    = wrap_inc(3'(i));
            in_ready[i] = 1'b1;
          end
        end
      end else if (out_ready[o]) begin
        valid_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        pkt_q[o] <= '0;
        ptr_q[o] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int o = 0; o < NUM_PORTS; o++) begin
        pkt_q[o] <= pkt_d[o];
        ptr_q[o] <= ptr_d[o];
      end
    end
  end

  always_comb begin
    out_packet = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_packet[PACKET_WIDTH*o +: PACKET_WIDTH] = pkt_q[o];
    end
  end

  assign out_valid = valid_q;
  assign drop_err  = |drop;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scenarios followed by randomized traffic, all checked against a
// per-cycle behavioural model of the allocation rules.
module tb_switch_allocator;

  localparam int NP = 5;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_valid;
  logic [3*NP-1:0]   in_dir;
  logic [PW*NP-1:0]  in_packet;
  logic [NP-1:0]     in_ready;
  logic [NP-1:0]     out_valid;
  logic [PW*NP-1:0]  out_packet;
  logic [NP-1:0]     out_ready;
  logic              drop_err;

  switch_allocator #(.PACKET_WIDTH(PW), .NUM_PORTS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_dir     (in_dir),
    .in_packet  (in_packet),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_packet (out_packet),
    .out_ready  (out_ready),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [2:0]  t_dir [NP];
  logic [31:0] t_pkt [NP];

  int          m_ptr [NP];
  bit          m_val [NP];
  logic [31:0] m_pkt [NP];

  logic [NP-1:0] obs_rdy;
  logic          obs_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NP-1:0] v, input logic [NP-1:0] ordy);
    logic [NP-1:0] e_rdy;
    logic          e_drop;
    bit            n_val [NP];
    logic [31:0]   n_pkt [NP];
    int            n_ptr [NP];
    int            g;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < NP; i++) begin
      in_dir[3*i +: 3]    = t_dir[i];
      in_packet[PW*i +: PW] = t_pkt[i];
    end
    #1;
    e_rdy  = '0;
    e_drop = 1'b0;
    n_val  = m_val;
    n_pkt  = m_pkt;
    n_ptr  = m_ptr;
    if (r) begin
      for (int o = 0; o < NP; o++) begin
        n_val[o] = 1'b0;
        n_pkt[o] = '0;
        n_ptr[o] = 0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (v[i] && t_dir[i] > 3'd4) begin
          e_rdy[i] = 1'b1;
          e_drop   = 1'b1;
        end
      end
      for (int o = 0; o < NP; o++) begin
        g = -1;
        if (!m_val[o] || ordy[o]) begin
          for (int k = 0; k < NP; k++) begin
            int src;
            src = (m_ptr[o] + k) % NP;
            if (g < 0 && v[src] && int'(t_dir[src]) == o) g = src;
          end
        end
        if (g >= 0) begin
          e_rdy[g] = 1'b1;
          n_val[o] = 1'b1;
          n_pkt[o] = t_pkt[g];
          n_ptr[o] = (g + 1) % NP;
        end else if (ordy[o]) begin
          n_val[o] = 1'b0;
        end
      end
    end
    obs_rdy  = in_ready;
    obs_drop = drop_err;
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("drop_err", 32'(drop_err), 32'(e_drop));
    m_val = n_val;
    m_pkt = n_pkt;
    m_ptr = n_ptr;
    @(posedge clk);
    #1;
    for (int o = 0; o < NP; o++) begin
      chk($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(m_val[o]));
      if (m_val[o] || r) chk($sformatf("out_packet[%0d]", o), out_packet[PW*o +: PW], m_pkt[o]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_dir    = '0;
    in_packet = '0;
    out_ready = '0;
    for (int i = 0; i < NP; i++) begin
      t_dir[i] = 3'd0;
      t_pkt[i] = 32'h0;
      m_ptr[i] = 0;
      m_val[i] = 1'b0;
      m_pkt[i] = 32'h0;
    end

    step(1'b1, 5'b00000, 5'b00000);
    step(1'b1, 5'b00000, 5'b00000);
    chk("reset_out_valid", 32'(out_valid), 32'h0);

    // Inputs 0,1,3 contend for East.
    t_dir[0] = 3'd2; t_dir[1] = 3'd2; t_dir[3] = 3'd2;
    t_pkt[0] = 32'hE000_0000; t_pkt[1] = 32'hE000_0001; t_pkt[3] = 32'hE000_0003;
    step(1'b0, 5'b01011, 5'b11111);
    chk("east_grant0", 32'(obs_rdy), 32'h01);
    chk("east_pkt0", out_packet[2*PW +: PW], 32'hE000_0000);
    step(1'b0, 5'b01010, 5'b11111);
    chk("east_grant1", 32'(obs_rdy), 32'h02);
    step(1'b0, 5'b01000, 5'b11111);
    chk("east_grant3", 32'(obs_rdy), 32'h08);
    chk("east_pkt3", out_packet[2*PW +: PW], 32'hE000_0003);
    step(1'b0, 5'b00000, 5'b11111);

    // Local input to North under backpressure.
    t_dir[4] = 3'd0; t_pkt[4] = 32'hB000_0000;
    step(1'b0, 5'b10000, 5'b00000);
    chk("north_first", 32'(obs_rdy), 32'h10);
    t_pkt[4] = 32'hB000_0001;
    repeat (3) begin
      step(1'b0, 5'b10000, 5'b00000);
      chk("north_hold_rdy", 32'(obs_rdy), 32'h00);
      chk("north_stable", out_packet[0 +: PW], 32'hB000_0000);
    end
    step(1'b0, 5'b10000, 5'b00001);
    chk("north_refill_rdy", 32'(obs_rdy), 32'h10);
    chk("north_refill_pkt", out_packet[0 +: PW], 32'hB000_0001);

    // Every input to a distinct output.
    for (int i = 0; i < NP; i++) begin
      t_dir[i] = 3'((i + 1) % NP);
      t_pkt[i] = 32'hC000_0000 + 32'(i);
    end
    step(1'b0, 5'b11111, 5'b11111);
    chk("all_rdy", 32'(obs_rdy), 32'h1F);
    chk("all_valid", 32'(out_valid), 32'h1F);

    // Illegal direction is dropped.
    t_dir[2] = 3'd6;
    step(1'b0, 5'b00100, 5'b00000);
    chk("drop_rdy", 32'(obs_rdy), 32'h04);
    chk("drop_flag", 32'(obs_drop), 32'h1);
    chk("drop_no_load", 32'(out_valid), 32'h1F);
    step(1'b0, 5'b00000, 5'b00000);
    chk("drop_pulse_end", 32'(obs_drop), 32'h0);

    // Reset mid-operation, then Local contention restarts at input 0.
    step(1'b0, 5'b00000, 5'b01010);
    chk("pre_reset_valid", 32'(out_valid), 32'h15);
    step(1'b1, 5'b11111, 5'b00000);
    chk("reset_rdy", 32'(obs_rdy), 32'h00);
    chk("reset_clears", 32'(out_valid), 32'h00);
    t_dir[0] = 3'd4; t_dir[3] = 3'd4;
    step(1'b0, 5'b01001, 5'b11111);
    chk("local_first", 32'(obs_rdy), 32'h01);
    step(1'b0, 5'b01000, 5'b11111);
    chk("local_second", 32'(obs_rdy), 32'h08);

    // Random traffic.
    repeat (400) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 9) < 9) t_dir[i] = 3'($urandom_range(0, 4));
        else                          t_dir[i] = 3'($urandom_range(5, 7));
        t_pkt[i] = 32'($urandom);
      end
      step(1'($urandom_range(0, 39) == 0), 5'($urandom), 5'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter PACKET_WIDTH, default 32, SHALL set the packet width (bits [31:16] dest addr, [15:0] neuron addr).
REQ-002 Parameter NUM_PORTS, default 5, SHALL set the port count; index 0=North, 1=South, 2=East, 3=West, 4=Local. Only 5 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  NUM_PORTS  SHALL flag that input port i holds a packet.
REQ-006 in_dir  input  3*NUM_PORTS  SHALL carry the route direction of input i in bits [3i+2:3i], encoded 0=N, 1=S, 2=E, 3=W, 4=Local.
REQ-007 in_packet  input  PACKET_WIDTH*NUM_PORTS  SHALL carry the packet of input i.
REQ-008 in_ready  output  NUM_PORTS  SHALL pulse high in the cycle input i's packet is consumed (grant/pop).
REQ-009 out_valid  output  NUM_PORTS  SHALL flag that output register o holds a packet.
REQ-010 out_packet  output  PACKET_WIDTH*NUM_PORTS  SHALL carry the packet held in output register o.
REQ-011 out_ready  input  NUM_PORTS  SHALL indicate that the downstream of output o accepts a packet this cycle.
REQ-012 drop_err  output  1  SHALL pulse high for one cycle when any packet with in_dir > 4 is discarded.

Function
REQ-013 Each output o SHALL have a one-entry register (valid bit plus packet) and a 3-bit round-robin pointer ptr[o].
REQ-014 Output o SHALL be "free" in a cycle when out_valid[o]==0, or when out_valid[o]==1 and out_ready[o]==1 (same-cycle drain and refill).
REQ-015 Requesters for o SHALL be all inputs i with in_valid[i]==1 and in_dir_i==o.
REQ-016 When o is free and has at least one requester, exactly one SHALL be granted: the first requester at or after ptr[o], scanning upward modulo 5.
REQ-017 On a grant to input i for output o, in_ready[i] SHALL be 1 combinationally in that cycle; the packet SHALL load into register o at the next edge; ptr[o] SHALL become (i+1) mod 5.
REQ-018 ptr[o] SHALL hold its value in cycles with no grant on o.
REQ-019 in_ready[i] SHALL be 0 whenever in_valid[i]==0 or input i is not granted. Each input requests only one output, so it receives at most one grant per cycle.
REQ-020 Latency: a packet granted in cycle t SHALL appear on out_valid/out_packet in cycle t+1; back-to-back throughput SHALL be one packet per output per cycle while out_ready stays high.
REQ-021 A handshake (out_valid[o] & out_ready[o]) with no new grant on o SHALL clear out_valid[o] at the next edge; out_packet SHALL remain stable while out_valid[o]==1 and out_ready[o]==0.
REQ-022 in_valid[i] with in_dir_i in 5..7 SHALL produce in_ready[i]=1 in that cycle, load no output, leave every pointer unchanged, and assert drop_err.
REQ-023 Outputs SHALL be arbitrated independently; up to 5 grants per cycle to distinct outputs SHALL be allowed.
REQ-024 out_ready[o] asserted while out_valid[o]==0 SHALL have no effect.

Reset
REQ-025 With rst high at a clock edge: all out_valid SHALL be 0, out_packet 0, all ptr[o] 0.
REQ-026 During rst, in_ready and drop_err SHALL be 0; packets held in registers at reset SHALL be lost (reset mid-operation discards them).
REQ-027 The first grant after rst falls SHALL follow pointer value 0 for every output.

Structure
REQ-028 Direction codes (NORTH..LOCAL), NUM_PORTS and PACKET_WIDTH defaults SHALL live in a shared NoC package, also used by input_router.
REQ-029 One sub-module, rr_arbiter (5-bit request vector, 3-bit pointer in, one-hot grant out, combinational), SHALL be instantiated once per output; the registers live in switch_allocator.

Verification
REQ-030 Reset, then inputs 0,1,3 all request East (dir 2) with out_ready[2]=1 held -> grants in order 0,1,3 on consecutive cycles; out_packet East matches each packet one cycle after its grant.
REQ-031 Input 4 requests North with out_ready[0]=0 for 3 cycles -> first packet loads, in_ready[4]=0 for the next 3 cycles, out_packet stable; out_ready[0]=1 -> drain and the next packet refill in the same cycle.
REQ-032 All 5 inputs request distinct outputs in one cycle -> in_ready=5'b11111, all out_valid=1 the next cycle.
REQ-033 Input 2 asserts in_valid with in_dir=6 -> in_ready[2]=1 and drop_err=1 for one cycle, no out_valid change, pointers unchanged.
REQ-034 rst asserted while out_valid=5'b10101 -> all out_valid=0 and all ptr=0 on the next cycle; the following contention on Local between inputs 3 and 0 grants input 0 first.
